// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the execute-stage front end and the
// iterative multiply/divide unit. The master issues requests and the slave
// (the unit) returns busy/done and the register-file write-back fields.
interface mul_div_unit_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
);
  logic                     start;
  logic [2:0]               funct3;
  logic [DATA_WIDTH-1:0]    op_a;
  logic [DATA_WIDTH-1:0]    op_b;
  logic [ADDRESS_WIDTH-1:0] rd_in;
  logic                     busy;
  logic                     done;
  logic [DATA_WIDTH-1:0]    result;
  logic [ADDRESS_WIDTH-1:0] rd_out;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. One radix-2 step per cycle on operand
// magnitudes, followed by a single sign-fix cycle and a one-cycle done pulse
// that drives the register file write port. Latency is DATA_WIDTH+2 cycles
// from acceptance to done, identical for every op and every operand value.
module mul_div_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_div_unit_if.slave  bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  // funct3 codes whose rs1 / rs2 operand is interpreted as signed.
  // MUL is handled as unsigned because its low product word is sign-agnostic.
  // Bit index = funct3: MULH(1), MULHSU(2), DIV(4), REM(6) sign rs1;
  // MULH(1), DIV(4), REM(6) sign rs2.
  localparam logic [7:0] A_SIGNED_MASK = 8'b0101_0110;
  localparam logic [7:0] B_SIGNED_MASK = 8'b0101_0010;

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Control and output registers
  state_t                   state_reg;
  logic [CNT_W-1:0]         count_reg;
  logic                     busy_reg;
  logic                     done_reg;
  logic [W-1:0]             result_reg;
  logic [ADDRESS_WIDTH-1:0] rd_out_reg;

  // Operation context captured at acceptance
  logic [2:0]               op_reg;
  logic [ADDRESS_WIDTH-1:0] rd_latch_reg;
  logic [W-1:0]             a_mag_reg;     // multiplicand magnitude (mul only)
  logic [W-1:0]             b_mag_reg;     // divisor magnitude (div only)
  logic [W-1:0]             a_orig_reg;    // raw rs1, returned by REM/REMU on x/0
  logic                     a_neg_reg;
  logic                     b_neg_reg;
  logic                     div_zero_reg;
  logic                     ovf_reg;

  // Datapath state: 2W accumulator plus an operand shift register.
  // Multiply: acc high half is the running partial sum, low half collects the
  // product bits shifted out; opd holds the multiplier and shifts right.
  // Divide: acc high half is the partial remainder, low half collects quotient
  // bits; opd holds the dividend and shifts left, feeding one bit per step.
  logic [2*W-1:0]           acc_reg;
  logic [W-1:0]             opd_reg;

  // Acceptance-side decode of the incoming request
  logic                     a_signed_in;
  logic                     b_signed_in;
  logic                     a_neg_in;
  logic                     b_neg_in;
  logic [W-1:0]             a_mag_in;
  logic [W-1:0]             b_mag_in;
  logic                     ovf_in;

  // Per-cycle iteration results
  logic [W:0]               mul_sum;
  logic [2*W-1:0]           mul_acc_next;
  logic [W-1:0]             mul_opd_next;
  logic [W:0]               div_trial;
  logic [W+1:0]             div_diff;
  logic                     div_ok;
  logic [W-1:0]             div_rem;
  logic [2*W-1:0]           div_acc_next;
  logic [W-1:0]             div_opd_next;
  logic [2*W-1:0]           acc_next;
  logic [W-1:0]             opd_next;

  // Sign-fix stage
  logic [2*W-1:0]           prod_fixed;
  logic [W-1:0]             quot_fixed;
  logic [W-1:0]             rem_fixed;
  logic [W-1:0]             result_next;

  // Decode signedness, magnitudes and the signed-overflow case of a request
  always_comb begin
    a_signed_in = A_SIGNED_MASK[bus.funct3];
    b_signed_in = B_SIGNED_MASK[bus.funct3];
    a_neg_in    = a_signed_in & bus.op_a[W-1];
    b_neg_in    = b_signed_in & bus.op_b[W-1];
    a_mag_in    = a_neg_in ? -bus.op_a : bus.op_a;
    b_mag_in    = b_neg_in ? -bus.op_b : bus.op_b;
    ovf_in      = ((bus.funct3 == 3'b100) || (bus.funct3 == 3'b110)) &&
                  (bus.op_a == MIN_VAL) && (bus.op_b == {W{1'b1}});
  end

  // One shift-add (multiply) or restoring (divide) step on the magnitudes
  always_comb begin
    mul_sum      = {1'b0, acc_reg[2*W-1:W]} + (opd_reg[0] ? {1'b0, a_mag_reg} : {(W+1){1'b0}});
    mul_acc_next = {mul_sum, acc_reg[W-1:1]};
    mul_opd_next = {1'b0, opd_reg[W-1:1]};

    div_trial    = {acc_reg[2*W-1:W], opd_reg[W-1]};
    div_diff     = {1'b0, div_trial} - {2'b00, b_mag_reg};
    div_ok       = ~div_diff[W+1];
    div_rem      = div_ok ? div_diff[W-1:0] : div_trial[W-1:0];
    div_acc_next = {div_rem, acc_reg[W-2:0], div_ok};
    div_opd_next = {opd_reg[W-2:0], 1'b0};

    if (op_reg[2]) begin
      acc_next = div_acc_next;
      opd_next = div_opd_next;
    end else begin
      acc_next = mul_acc_next;
      opd_next = mul_opd_next;
    end
  end

  // Sign correction and final result selection, with x/0 and overflow overrides
  always_comb begin
    prod_fixed  = (a_neg_reg ^ b_neg_reg) ? -acc_reg : acc_reg;
    quot_fixed  = (a_neg_reg ^ b_neg_reg) ? -acc_reg[W-1:0] : acc_reg[W-1:0];
    rem_fixed   = a_neg_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
    result_next = '0;
    case (op_reg)
      3'b000: result_next = prod_fixed[W-1:0];
      3'b001,
      3'b010,
      3'b011: result_next = prod_fixed[2*W-1:W];
      3'b100,
      3'b101: begin
        if (div_zero_reg)  result_next = {W{1'b1}};
        else if (ovf_reg)  result_next = MIN_VAL;
        else               result_next = quot_fixed;
      end
      default: begin
        if (div_zero_reg)  result_next = a_orig_reg;
        else if (ovf_reg)  result_next = '0;
        else               result_next = rem_fixed;
      end
    endcase
  end

  // Control FSM with registered busy/done/result/rd_out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      result_reg   <= '0;
      rd_out_reg   <= '0;
      op_reg       <= '0;
      rd_latch_reg <= '0;
      a_mag_reg    <= '0;
      b_mag_reg    <= '0;
      a_orig_reg   <= '0;
      a_neg_reg    <= 1'b0;
      b_neg_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      acc_reg      <= '0;
      opd_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            op_reg       <= bus.funct3;
            rd_latch_reg <= bus.rd_in;
            a_mag_reg    <= a_mag_in;
            b_mag_reg    <= b_mag_in;
            a_orig_reg   <= bus.op_a;
            a_neg_reg    <= a_neg_in;
            b_neg_reg    <= b_neg_in;
            div_zero_reg <= (bus.op_b == '0);
            ovf_reg      <= ovf_in;
            acc_reg      <= '0;
            opd_reg      <= bus.funct3[2] ? a_mag_in : b_mag_in;
            count_reg    <= '0;
            busy_reg     <= 1'b1;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          acc_reg   <= acc_next;
          opd_reg   <= opd_next;
          count_reg <= count_reg + CNT_W'(1);
          if (count_reg == CNT_W'(W-1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_reg <= result_next;
          rd_out_reg <= rd_latch_reg;
          done_reg   <= 1'b1;
          state_reg  <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          count_reg <= '0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.result = result_reg;
  assign bus.rd_out = rd_out_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: per-op results, exact
// done timing, ignored starts while busy, and reset mid-operation.
module tb_mul_div_unit;

  logic clk = 1'b0;
  logic rst_n;

  mul_div_unit_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) bus ();

  mul_div_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current cycle (cycle 0) and follow it through
  // cycle 35. Optionally pulse extra starts in cycles 10 and 34.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit inject);
    int n_done   = 0;
    int done_cyc = 0;
    bit busy_ok  = 1'b1;
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    tick();
    // Operand changes after acceptance must not matter.
    bus.start  = 1'b0;
    bus.funct3 = f ^ 3'b001;
    bus.op_a   = ~a;
    bus.op_b   = a;
    bus.rd_in  = ~rd;
    for (int k = 1; k <= 34; k++) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        done_cyc = k;
      end
      if (k == 34) begin
        check({tag, ".result"}, bus.result, exp);
        check({tag, ".rd_out"}, 32'(bus.rd_out), 32'(rd));
      end
      if (inject && (k == 10 || k == 34)) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'h0000_0005;
        bus.op_b   = 32'h0000_0003;
        bus.rd_in  = rd ^ 5'h1f;
      end else begin
        bus.start = 1'b0;
      end
      tick();
    end
    bus.start = 1'b0;
    check({tag, ".busy_run"}, 32'(busy_ok), 32'd1);
    check({tag, ".done_cnt"}, 32'(n_done), 32'd1);
    check({tag, ".done_cyc"}, 32'(done_cyc), 32'd34);
    check({tag, ".busy_c35"}, 32'(bus.busy), 32'd0);
    check({tag, ".done_c35"}, 32'(bus.done), 32'd0);
    check({tag, ".hold_c35"}, bus.result, exp);
    $display("op %s funct3=%0d a=0x%08h b=0x%08h rd=%0d -> result=0x%08h (exp 0x%08h) done_cycle=%0d",
             tag, f, a, b, rd, bus.result, exp, done_cyc);
  endtask

  initial begin
    int n_done;

    // Reset with start held high: the start on the reset edge is ignored.
    rst_n      = 1'b0;
    bus.start  = 1'b1;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd9;
    bus.op_b   = 32'd9;
    bus.rd_in  = 5'd4;
    tick();
    tick();
    check("rst.busy",   32'(bus.busy),   32'd0);
    check("rst.done",   32'(bus.done),   32'd0);
    check("rst.result", bus.result,      32'd0);
    check("rst.rd_out", 32'(bus.rd_out), 32'd0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    tick();
    check("rst.start_ignored", 32'(bus.busy), 32'd0);
    $display("reset released");

    run_op("MUL",       3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
    run_op("MULH",      3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1'b0);
    run_op("MULHU",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0);
    run_op("MULHSU",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 1'b0);
    run_op("DIV",       3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 1'b0);
    run_op("REM",       3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 1'b0);
    run_op("DIVU",      3'b101, 32'd100,        32'd7,         5'd11, 32'd14,        1'b0);
    run_op("REMU",      3'b111, 32'd100,        32'd7,         5'd12, 32'd2,         1'b0);
    run_op("DIVU_by0",  3'b101, 32'h0000_1234, 32'd0,         5'd13, 32'hFFFF_FFFF, 1'b0);
    run_op("REM_by0",   3'b110, 32'h0000_1234, 32'd0,         5'd14, 32'h0000_1234, 1'b0);
    run_op("DIV_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b0);
    run_op("REM_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         1'b0);

    // Starts in cycles 10 and 34 are dropped; the follow-up in cycle 35 lands at 69.
    run_op("DIVU_busy", 3'b101, 32'd1000,       32'd9,         5'd3,  32'd111,       1'b1);
    run_op("MULHU_b2b", 3'b011, 32'h0001_0000, 32'h0003_0000, 5'd17, 32'h0000_0003, 1'b0);

    // Reset during a DIV in cycle 20 aborts it with no done pulse.
    bus.start  = 1'b1;
    bus.funct3 = 3'b100;
    bus.op_a   = 32'd1000;
    bus.op_b   = 32'd7;
    bus.rd_in  = 5'd9;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k < 20; k++) tick();
    rst_n = 1'b0;
    tick();
    check("abort.busy",   32'(bus.busy),   32'd0);
    check("abort.done",   32'(bus.done),   32'd0);
    check("abort.result", bus.result,      32'd0);
    check("abort.rd_out", 32'(bus.rd_out), 32'd0);
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.done === 1'b1) n_done++;
      tick();
    end
    check("abort.no_done", 32'(n_done), 32'd0);
    $display("reset mid-DIV: aborted, done pulses afterwards=%0d", n_done);

    run_op("MUL_after_rst", 3'b000, 32'd3, 32'd5, 5'd21, 32'd15, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit on the execute side of the register file. It consumes the two register read values (RD1/RD2) plus the destination index. After a fixed latency it returns a result, destination index and one-cycle write-enable pulse that drive the register file write port (WD3/AD3/WE3) directly. The pipeline front end stalls on `busy`.

## Interface
- `DATA_WIDTH`, 32: operand/result width; latency scales as DATA_WIDTH+2; only 32 is verified.
- `ADDRESS_WIDTH`, 5: destination register index width.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `clk` rising edge.
- `start`  in  1  request; accepted only when `busy`=0.
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  in  DATA_WIDTH  rs1 value (from RD1); multiplicand/dividend.
- `op_b`  in  DATA_WIDTH  rs2 value (from RD2); multiplier/divisor.
- `rd_in`  in  ADDRESS_WIDTH  destination index for the request.
- `busy`  out  1  operation in flight; front end stalls.
- `done`  out  1  one-cycle pulse: result valid; wired to WE3.
- `result`  out  DATA_WIDTH  result; wired to WD3.
- `rd_out`  out  ADDRESS_WIDTH  latched `rd_in`; wired to AD3.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: `start`=1 latches `funct3`, `rd_in`, and operand magnitudes plus sign flags. Signed operands per op: MULH and DIV/REM both signed; MULHSU `op_a` signed only; MUL treated as unsigned (low word identical). Clears the 64-bit accumulator and iteration counter, then goes to CALC.
- CALC: exactly DATA_WIDTH iterations, one per cycle, counter 0..DATA_WIDTH-1.
  - Multiply: shift-add on magnitudes into a 2*DATA_WIDTH product.
  - Divide: restoring division; per cycle, shift remainder left, bring in next dividend bit, subtract divisor if no borrow, shift quotient bit in.
  - At counter = DATA_WIDTH-1, go to FIX.
- FIX: apply sign correction by two's-complement negation.
  - Product negated if the operand signs differ.
  - Quotient negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Selects the result: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder.
  - Goes to DONE.
- Special cases, resolved in FIX and overriding the datapath:
  - Divisor 0: DIV/DIVU quotient = all ones; REM/REMU = original `op_a`.
  - DIV with `op_a`=0x80000000, `op_b`=0xFFFFFFFF: quotient 0x80000000, REM 0.
- DONE: `done`=1 for this cycle only, then IDLE.
- `result`/`rd_out` are registered, change only in FIX, and hold until the next FIX.
- `start` while `busy`=1 is ignored and not queued.
- Operand/`funct3`/`rd_in` changes after acceptance have no effect.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter 0.
- Reset mid-operation aborts the operation with no `done` pulse. A `start` on the same edge as reset is ignored.
- `start` sampled at the end of cycle 0:
  - `busy`=1 in cycles 1..DATA_WIDTH+2 (1..34).
  - CALC in cycles 1..32, FIX in cycle 33, DONE in cycle 34.
  - `done`=1 and `result`/`rd_out` valid in cycle 34, so the register file writes on the edge ending cycle 34.
- `busy`=1 during the `done` cycle, so a `start` in cycle 34 is ignored; the earliest new accept is the end of cycle 35.
- Back-to-back throughput: one operation per 35 cycles.
- Latency is fixed for every op, including divide-by-zero and overflow; there is no early termination.
- `busy`/`done` are registered outputs with no combinational path from inputs.

## Test plan
- MUL: `op_a`=7, `op_b`=0xFFFFFFFD -> `result`=0xFFFFFFEB, `done` pulse in cycle 34 only, `rd_out`=`rd_in`.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divisor 0: DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
- `start` pulsed in cycles 10 and 34 with different operands and `rd_in` -> both ignored, first result unchanged; `start` in cycle 35 accepted with `done` in cycle 69.
- `rst_n`=0 in cycle 20 of a DIV -> `busy`/`done`/`result`/`rd_out` all 0 next cycle, no `done` pulse afterwards; a new MUL 3×5 then completes with 15 at full latency.
